// File: rtl/fm_frag_server.sv
// fm_frag_server: ping-pong fragment-memory read responder for the Extender
// Ports:
//   clk, rst_n                              clock (rising edge), asynchronous active-low reset
//   wr_valid, wr_ready, wr_base             base stream from the FM loader into the fill buffer
//   req_valid, req_ready, req_index         signed fragment start index, relative to the read buffer
//   rsp_valid, rsp_ready, rsp_frag, rsp_mask registered fragment and per-base real-data mask
//   rel                                     pulse releasing the current read buffer
//   buf_full                                per-buffer readable flag
// Define FM_FRAG_SERVER_WRAP_EN to take indices modulo FM_BUFFER_SIZE instead of zero-padding.
module fm_frag_server #(
  parameter int BASE_LEN          = 2,
  parameter int FRAG_LEN          = 8,
  parameter int FM_BUFFER_COUNT   = 2,
  parameter int FM_BUFFER_SIZE    = 32,
  parameter int INDICE_LEN        = $clog2(FM_BUFFER_SIZE),
  parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [BASE_LEN-1:0]          wr_base,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [SIGNED_INDICE_LEN-1:0] req_index,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BASE_LEN*FRAG_LEN-1:0] rsp_frag,
  output logic [FRAG_LEN-1:0]          rsp_mask,
  input  logic                         rel,
  output logic [FM_BUFFER_COUNT-1:0]   buf_full
);
`ifdef FM_FRAG_SERVER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int PW = FM_BUFFER_COUNT > 1 ? $clog2(FM_BUFFER_COUNT) : 1;
  localparam int SW = SIGNED_INDICE_LEN + 1;
  localparam logic [INDICE_LEN-1:0] LAST = INDICE_LEN'(FM_BUFFER_SIZE - 1);
  localparam logic [INDICE_LEN-1:0] ONE = INDICE_LEN'(1);
  localparam logic [PW-1:0] PLAST = PW'(FM_BUFFER_COUNT - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_st_t;
  typedef enum logic [1:0] {IDLE, SERVE, RESP} rd_st_t;
  buf_st_t bst_q [FM_BUFFER_COUNT];
  buf_st_t bst_d [FM_BUFFER_COUNT];
  rd_st_t st_q, st_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [INDICE_LEN-1:0] off_q, off_d;
  logic pend_q, pend_d;
  logic [BASE_LEN*FRAG_LEN-1:0] frag_q, frag_d;
  logic [FRAG_LEN-1:0] mask_q, mask_d;
  logic [BASE_LEN-1:0] mem_q [FM_BUFFER_COUNT][FM_BUFFER_SIZE];
  logic [SW-1:0] idx [FRAG_LEN];
  logic wr_fire, req_fire, rel_eff, rp_full, do_rel;
  assign wr_ready  = bst_q[wp_q] != FULL;
  assign rp_full   = bst_q[rp_q] == FULL;
  assign req_ready = st_q == SERVE;
  assign rsp_valid = st_q == RESP;
  assign rsp_frag  = frag_q;
  assign rsp_mask  = mask_q;
  assign wr_fire   = wr_valid & wr_ready;
  assign req_fire  = req_valid & req_ready;
  // a release deferred from RESP is replayed once the FSM is back in SERVE
  assign rel_eff   = rel | pend_q;
  // a request in the same SERVE cycle wins; the release then stays pending
  assign do_rel    = st_q != RESP && rel_eff && rp_full && !req_fire;
  always_comb begin
    buf_full = '0;
    for (int i = 0; i < FM_BUFFER_COUNT; i++) buf_full[i] = bst_q[i] == FULL;
  end
  always_comb begin
    bst_d = bst_q;
    wp_d  = wp_q;
    off_d = off_q;
    rp_d  = rp_q;
    if (wr_fire) begin
      bst_d[wp_q] = off_q == LAST ? FULL : FILLING;
      off_d = off_q == LAST ? '0 : off_q + ONE;
      wp_d = off_q != LAST ? wp_q : wp_q == PLAST ? '0 : wp_q + PONE;
    end
    // write and release never target the same buffer: one needs FULL, the other not FULL
    if (do_rel) begin
      bst_d[rp_q] = EMPTY;
      rp_d = rp_q == PLAST ? '0 : rp_q + PONE;
    end
    st_d = do_rel ? IDLE :
           req_fire ? RESP :
           st_q == RESP && rsp_ready ? SERVE :
           st_q == IDLE && rp_full ? SERVE : st_q;
    pend_d = st_q == RESP ? pend_q | rel : req_fire & rel_eff;
  end
  // the sum is one bit wider than req_index, so an index is in range exactly when its top two bits are zero
  always_comb begin
    frag_d = '0;
    mask_d = '0;
    for (int k = 0; k < FRAG_LEN; k++) begin
      idx[k] = {req_index[SIGNED_INDICE_LEN-1], req_index} + SW'(k);
      mask_d[k] = WRAP || idx[k][SW-1:INDICE_LEN] == '0;
      frag_d[BASE_LEN*k +: BASE_LEN] = mask_d[k] ? mem_q[rp_q][idx[k][INDICE_LEN-1:0]] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst_q  <= '{default: EMPTY};
      st_q   <= IDLE;
      wp_q   <= '0;
      rp_q   <= '0;
      off_q  <= '0;
      pend_q <= 1'b0;
      frag_q <= '0;
      mask_q <= '0;
    end else begin
      bst_q  <= bst_d;
      st_q   <= st_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      off_q  <= off_d;
      pend_q <= pend_d;
      if (req_fire) begin
        frag_q <= frag_d;
        mask_q <= mask_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wp_q][off_q] <= wr_base;
  end
endmodule
